mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, executing MIPS MULT, MULTU, DIV and DIVU beside the single-cycle ALU. Operand width is parametrised. The unit uses a start/busy/done handshake so the controller can stall HI/LO consumers. Direct HI/LO writes serve MTHI/MTLO, and the HI/LO outputs serve MFHI/MFLO.

## Interface
- N, default 32: operand width; HI and LO are each N bits; iteration count is N.
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- inA  input  N  multiplicand or dividend; sampled with start.
- inB  input  N  multiplier or divisor; sampled with start.
- hi_wen  input  1  MTHI: hi <= wd; honoured only in IDLE.
- lo_wen  input  1  MTLO: lo <= wd; honoured only in IDLE.
- wd  input  N  write data for hi_wen/lo_wen.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; hi/lo hold the new result.
- div_by_zero  output  1  sticky flag, updated at each done: 1 iff that operation was a divide with inB == 0.
- hi  output  N  HI register: product upper half, or remainder.
- lo  output  N  LO register: product lower half, or quotient.

## Operation
- States: IDLE, CALC, FIX. Iteration counter width is clog2(N)+1.
- IDLE + start:
  - Latch op.
  - For signed ops, latch |inA| and |inB|, plus result sign flags.
    - Product sign: sign(inA) XOR sign(inB).
    - Quotient sign: sign(inA) XOR sign(inB).
    - Remainder sign: sign(inA).
  - Clear the counter. Raise busy.
  - Go to CALC, or go straight to FIX if op is a divide and inB == 0.
- CALC, multiply: shift-add over a 2N-bit accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle. The N-bit remainder is compared/subtracted at N+1 bits.
- CALC exits to FIX after exactly N iterations.
- FIX:
  - Negate results as required (two's complement, truncated to N bits).
  - Multiply: {hi,lo} <= 2N-bit product.
  - Divide: lo <= quotient, hi <= remainder.
  - Divide by zero: hi and lo unchanged, div_by_zero <= 1.
  - Otherwise div_by_zero <= 0.
  - done <= 1, busy <= 0, go to IDLE.
- DIV of most-negative by -1: lo = most-negative (wrap), hi = 0. No flag.
- start, op, inA and inB are ignored outside IDLE. The operation always uses the values latched at acceptance.
- hi_wen/lo_wen outside IDLE are ignored (dropped, not queued).
- hi_wen/lo_wen together with an accepted start: the write is performed; the operation's result later overwrites it.
- hi_wen and lo_wen together: both are written with wd.

## Timing
- Reset (async, any state, including mid-CALC):
  - State IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0.
  - Any in-flight operation is discarded.
- Start accepted at edge E0: busy=1 after E0.
- Normal operation:
  - Iterations occur on E1..EN; state becomes FIX after EN.
  - E(N+1) writes hi/lo; after E(N+1), done=1 and busy=0.
  - Latency is N+1 edges from acceptance (33 for N=32).
- Divide by zero: FIX after E0; done and flag after E1 (latency 1).
- done is high for exactly one cycle; it drops on the next edge unless another done occurs.
- The done cycle is IDLE, so a start during that cycle is accepted. Back-to-back throughput is N+1 cycles per operation.
- hi/lo change only at FIX, at a direct write, or at reset; they are stable throughout CALC.

## Test plan
- Reset, then MULTU inA=0xFFFFFFFF, inB=0xFFFFFFFF -> done after 33 edges; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT inA=-3 (0xFFFFFFFD), inB=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV inA=-7, inB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU inA=7, inB=2 -> lo=3, hi=1. DIV 0x80000000 by -1 -> lo=0x80000000, hi=0.
- DIVU inA=5, inB=0, with hi preloaded via hi_wen wd=0x1234 -> done after 1 edge; div_by_zero=1; hi=0x1234 unchanged. Next MULTU 2*3 -> lo=6, div_by_zero=0.
- start pulsed with different operands while busy, plus lo_wen while busy -> both ignored. New start asserted on the done cycle -> accepted; second done exactly 33 cycles later.
- Reset asserted at CALC iteration 10 -> immediately busy=0, done=0, hi=lo=0. Subsequent MULTU 4*4 -> lo=16 with full 33-edge latency.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         hi_wen,
  input  logic         lo_wen,
  input  logic [N-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic           div_q;
  logic           neg_q;
  logic           rem_neg_q;
  logic           dbz_q;
  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [2*N-1:0] acc;

  logic           b_zero;
  logic [N-1:0]   abs_a;
  logic [N-1:0]   abs_b;
  logic [N:0]     mul_sum;
  logic [N:0]     mul_hi;
  logic [N:0]     div_r;
  logic [N:0]     div_d;
  logic           qbit;
  logic [N-1:0]   new_rem;
  logic [2*N-1:0] mul_next;
  logic [2*N-1:0] div_next;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quo;
  logic [N-1:0]   rem;

  // Signed ops run on magnitudes; the most-negative value maps onto its own bit pattern,
  // which read unsigned is exactly the right magnitude.
  always_comb begin
    b_zero = (inB == '0);
    abs_a  = (op[0] && inA[N-1]) ? -inA : inA;
    abs_b  = (op[0] && inB[N-1]) ? -inB : inB;
  end

  // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*N-1:N]} + {1'b0, mag_a};
    mul_hi   = acc[0] ? mul_sum : {1'b0, acc[2*N-1:N]};
    mul_next = {mul_hi, acc[N-1:1]};
    div_r    = {acc[2*N-1:N], acc[N-1]};
    div_d    = div_r - {1'b0, mag_b};
    qbit     = (div_r >= {1'b0, mag_b});
    new_rem  = qbit ? div_d[N-1:0] : div_r[N-1:0];
    div_next = {new_rem, acc[N-2:0], qbit};
    prod     = neg_q ? -acc : acc;
    quo      = neg_q ? -acc[N-1:0] : acc[N-1:0];
    rem      = rem_neg_q ? -acc[2*N-1:N] : acc[2*N-1:N];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start) state_next = (op[1] && b_zero) ? FIX : CALC;
      CALC:    if (cnt == CW'(N - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      div_q       <= 1'b0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      dbz_q       <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      acc         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_wen) hi <= wd;
          if (lo_wen) lo <= wd;
          if (start) begin
            div_q     <= op[1];
            neg_q     <= op[0] & (inA[N-1] ^ inB[N-1]);
            rem_neg_q <= op[0] & inA[N-1];
            dbz_q     <= op[1] & b_zero;
            mag_a     <= abs_a;
            mag_b     <= abs_b;
            cnt       <= '0;
            acc       <= op[1] ? {{N{1'b0}}, abs_a} : {{N{1'b0}}, abs_b};
          end
        end
        CALC: begin
          acc <= div_q ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (dbz_q) begin
            div_by_zero <= 1'b1;
          end else begin
            div_by_zero <= 1'b0;
            if (div_q) {hi, lo} <= {rem, quo};
            else       {hi, lo} <= prod;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit against an arithmetic reference
module tb_mult_div_unit;

  localparam int N = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [N-1:0] inA = '0;
  logic [N-1:0] inB = '0;
  logic         hi_wen = 1'b0;
  logic         lo_wen = 1'b0;
  logic [N-1:0] wd = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  mult_div_unit #(.N(N)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .wd(wd), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] m_hi = '0;
  logic [N-1:0] m_lo = '0;
  logic [N-1:0] pre_hi = '0;
  logic [N-1:0] pre_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: {div_by_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [N-1:0] a, b, ch, cl);
    logic [63:0] p;
    longint      sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin p = {32'h0, a} * {32'h0, b}; return {1'b0, p}; end
      2'd1: begin p = 64'(sa * sb); return {1'b0, p}; end
      2'd2: begin
        if (b == 0) return {1'b1, ch, cl};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, ch, cl};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("result_hi", hi, e.hi);
          chk("result_lo", lo, e.lo);
          chk("result_div_by_zero", div_by_zero, e.dbz);
          chk("done_cycle", cyc, e.due);
          chk("busy_on_done", busy, 0);
        end
      end else if (busy) begin
        chk("hi_stable_busy", hi, pre_hi);
        chk("lo_stable_busy", lo, pre_lo);
      end
    end
  end

  // Call right after a negedge while the unit is idle; returns at the next negedge.
  task automatic issue(input logic [1:0] o, input logic [N-1:0] a, b,
                       input logic hw, lw, input logic [N-1:0] w);
    exp_t        e;
    logic [64:0] r;
    if (hw) m_hi = w;
    if (lw) m_lo = w;
    pre_hi = m_hi;
    pre_lo = m_lo;
    r = model(o, a, b, m_hi, m_lo);
    e.dbz = r[64];
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.due = cyc + 1 + (r[64] ? 1 : N + 1);
    m_hi = e.hi;
    m_lo = e.lo;
    sbq.push_back(e);
    op = o; inA = a; inB = b; hi_wen = hw; lo_wen = lw; wd = w; start = 1'b1;
    @(negedge clock);
    start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
  endtask

  task automatic wait_done(input int lat, input string name);
    int n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clock);
    end
    chk({name, "_busy_cycles"}, n, lat);
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]   o;
    logic [N-1:0] a, b, w;
    logic         hw, lw;

    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", div_by_zero, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    reset = 1'b1;
    @(negedge clock);

    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    wait_done(33, "multu_max");
    chk("multu_max_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo, 32'h0000_0001);

    issue(2'd1, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
    wait_done(33, "mult_neg");
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFF1);

    issue(2'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    wait_done(33, "div_neg");
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    issue(2'd2, 32'd7, 32'd2, 0, 0, 0);
    wait_done(33, "divu");
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    wait_done(33, "div_wrap");
    chk("div_wrap_lo", lo, 32'h8000_0000);
    chk("div_wrap_hi", hi, 32'h0);
    chk("div_wrap_flag", div_by_zero, 0);

    hi_wen = 1'b1; wd = 32'h1234;
    @(negedge clock);
    hi_wen = 1'b0;
    m_hi = 32'h1234;
    chk("mthi", hi, 32'h1234);
    issue(2'd2, 32'd5, 32'd0, 0, 0, 0);
    wait_done(1, "dbz");
    chk("dbz_flag", div_by_zero, 1);
    chk("dbz_hi_kept", hi, 32'h1234);
    issue(2'd0, 32'd2, 32'd3, 0, 0, 0);
    wait_done(33, "after_dbz");
    chk("after_dbz_lo", lo, 32'd6);
    chk("after_dbz_flag", div_by_zero, 0);

    issue(2'd0, 32'd100, 32'd200, 0, 0, 0);
    repeat (5) @(negedge clock);
    start = 1'b1; op = 2'd3; inA = 32'd9; inB = 32'd0; lo_wen = 1'b1; wd = 32'hDEAD;
    @(negedge clock);
    start = 1'b0; lo_wen = 1'b0;
    chk("lo_wen_ignored", lo, pre_lo);
    wait_done(27, "ignore_busy");
    chk("ignore_busy_lo", lo, 32'd20000);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    wait_done(33, "back_to_back");
    chk("back_to_back_lo", lo, 32'd1);

    issue(2'd0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 0, 0);
    repeat (9) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_hi", hi, 0);
    chk("midreset_lo", lo, 0);
    chk("midreset_dbz", div_by_zero, 0);
    sbq.delete();
    m_hi = '0; m_lo = '0; pre_hi = '0; pre_lo = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    issue(2'd0, 32'd4, 32'd4, 0, 0, 0);
    wait_done(33, "post_reset");
    chk("post_reset_lo", lo, 32'd16);

    for (int i = 0; i < 40; i++) begin
      o  = 2'($urandom_range(0, 3));
      a  = pick();
      b  = ($urandom_range(0, 7) == 0) ? '0 : pick();
      hw = ($urandom_range(0, 5) == 0);
      lw = ($urandom_range(0, 5) == 0);
      w  = $urandom;
      issue(o, a, b, hw, lw, w);
      wait_done((o[1] && b == 0) ? 1 : 33, "random");
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
